// File: rtl/fp_vaddsub_seq.sv
// fp_vaddsub_seq
// Sequences one vector FP add/sub instruction (vd[i] = vs1[i] +/- vs2[i],
// i = 0..vl-1) onto a shared combinational FP add/sub unit. Elements are
// streamed through a two-stage pipeline at one element per cycle:
//   S1 holds the operands read from the VRF and feeds the FP unit,
//   S2 holds the FP result and presents it to the VRF write port.
// A write that is not accepted freezes the whole pipeline and the read index.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   cmd_*                  command handshake (valid/ready), vs1/vs2/vd, vl, sub
//   rd_a_*, rd_b_*         asynchronous VRF read ports ({reg, elem} address)
//   fu_a, fu_b, fu_sub     FP unit operands and subtract select
//   fu_y                   FP unit combinational result
//   wr_*                   VRF write port (valid/ready), {vd, elem} address
//   busy                   a command is in progress
//   done                   one-cycle completion pulse
module fp_vaddsub_seq #(
  parameter int WIDTH   = 32,
  parameter int REG_AW  = 5,
  parameter int ELEM_AW = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [REG_AW-1:0]          cmd_vs1,
  input  logic [REG_AW-1:0]          cmd_vs2,
  input  logic [REG_AW-1:0]          cmd_vd,
  input  logic [ELEM_AW:0]           cmd_vl,
  input  logic                       cmd_sub,
  output logic [REG_AW+ELEM_AW-1:0]  rd_a_addr,
  input  logic [WIDTH-1:0]           rd_a_data,
  output logic [REG_AW+ELEM_AW-1:0]  rd_b_addr,
  input  logic [WIDTH-1:0]           rd_b_data,
  output logic [WIDTH-1:0]           fu_a,
  output logic [WIDTH-1:0]           fu_b,
  output logic                       fu_sub,
  input  logic [WIDTH-1:0]           fu_y,
  output logic                       wr_valid,
  input  logic                       wr_ready,
  output logic [REG_AW+ELEM_AW-1:0]  wr_addr,
  output logic [WIDTH-1:0]           wr_data,
  output logic                       busy,
  output logic                       done
);

  localparam logic [ELEM_AW:0] MAXVL = {1'b1, {ELEM_AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [REG_AW-1:0]    vs1_q, vs1_d, vs2_q, vs2_d, vd_q, vd_d;
  logic                 sub_q, sub_d;
  logic [ELEM_AW:0]     vl_q, vl_d;
  logic [ELEM_AW-1:0]   rd_idx_q, rd_idx_d;
  logic                 s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
  logic [ELEM_AW-1:0]   s1_tag_q, s1_tag_d;
  logic                 s2_vld_q, s2_vld_d;
  logic [WIDTH-1:0]     s2_res_q, s2_res_d;
  logic [ELEM_AW-1:0]   s2_tag_q, s2_tag_d;
  logic                 done_q, done_d;

  logic                 stall;
  logic                 issue;
  logic                 last_issue;
  logic [ELEM_AW:0]     cmd_vl_eff;

  // Control, command latching and pipeline advance. A pending write that is
  // not accepted (stall) holds every piece of state, so the read address and
  // the write request stay stable until the handshake happens.
  always_comb begin
    state_d  = state_q;
    vs1_d    = vs1_q;
    vs2_d    = vs2_q;
    vd_d     = vd_q;
    sub_d    = sub_q;
    vl_d     = vl_q;
    rd_idx_d = rd_idx_q;
    s1_vld_d = s1_vld_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    s1_tag_d = s1_tag_q;
    s2_vld_d = s2_vld_q;
    s2_res_d = s2_res_q;
    s2_tag_d = s2_tag_q;
    done_d   = 1'b0;

    stall      = s2_vld_q & ~wr_ready;
    issue      = (state_q == RUN) & ~stall;
    last_issue = issue & ({1'b0, rd_idx_q} == (vl_q - 1'b1));
    cmd_vl_eff = (cmd_vl > MAXVL) ? MAXVL : cmd_vl;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          vs1_d    = cmd_vs1;
          vs2_d    = cmd_vs2;
          vd_d     = cmd_vd;
          sub_d    = cmd_sub;
          vl_d     = cmd_vl_eff;
          rd_idx_d = '0;
          // An empty vector completes immediately without touching the VRF.
          if (cmd_vl_eff == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (issue) begin
          rd_idx_d = rd_idx_q + 1'b1;
          if (last_issue) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Finish once S1 is empty and S2 is either empty or handing off its
        // final element this cycle; done then shows up in the IDLE cycle.
        if (!s1_vld_q && (!s2_vld_q || wr_ready)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!stall) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_res_d = fu_y;
        s2_tag_d = s1_tag_q;
      end
      s1_vld_d = issue;
      if (issue) begin
        op_a_d   = rd_a_data;
        op_b_d   = rd_b_data;
        s1_tag_d = rd_idx_q;
      end
    end
  end

  // State register with synchronous reset; reset mid-command drops every
  // in-flight element and suppresses the completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      vs1_q    <= '0;
      vs2_q    <= '0;
      vd_q     <= '0;
      sub_q    <= 1'b0;
      vl_q     <= '0;
      rd_idx_q <= '0;
      s1_vld_q <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      s1_tag_q <= '0;
      s2_vld_q <= 1'b0;
      s2_res_q <= '0;
      s2_tag_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vs1_q    <= vs1_d;
      vs2_q    <= vs2_d;
      vd_q     <= vd_d;
      sub_q    <= sub_d;
      vl_q     <= vl_d;
      rd_idx_q <= rd_idx_d;
      s1_vld_q <= s1_vld_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      s1_tag_q <= s1_tag_d;
      s2_vld_q <= s2_vld_d;
      s2_res_q <= s2_res_d;
      s2_tag_q <= s2_tag_d;
      done_q   <= done_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign rd_a_addr = {vs1_q, rd_idx_q};
  assign rd_b_addr = {vs2_q, rd_idx_q};
  assign fu_a      = op_a_q;
  assign fu_b      = op_b_q;
  assign fu_sub    = sub_q;
  assign wr_valid  = s2_vld_q;
  assign wr_addr   = {vd_q, s2_tag_q};
  assign wr_data   = s2_res_q;

endmodule

// File: tb/tb_fp_vaddsub_seq.sv
// tb_fp_vaddsub_seq
// Bench for fp_vaddsub_seq. Provides a behavioural VRF (async reads, writes on
// handshake) and a stand-in FP add/sub unit working on exactly representable
// half-integer values. Issued commands are expanded by a vector-level model
// into expected writes and completion events that a monitor compares against
// the DUT's write port and done pulse.
module tb_fp_vaddsub_seq;

  localparam int WIDTH   = 32;
  localparam int REG_AW  = 5;
  localparam int ELEM_AW = 3;
  localparam int AW      = REG_AW + ELEM_AW;
  localparam int NWORDS  = 1 << AW;

  typedef struct {
    int              cmdId;
    logic [AW-1:0]   addr;
    logic [31:0]     data;
    int              cyc;
  } wrExp_t;

  typedef struct {
    int cmdId;
    int cyc;
  } doneExp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [REG_AW-1:0] cmd_vs1 = '0, cmd_vs2 = '0, cmd_vd = '0;
  logic [ELEM_AW:0]  cmd_vl = '0;
  logic              cmd_sub = 1'b0;
  logic [AW-1:0]     rd_a_addr, rd_b_addr, wr_addr;
  logic [WIDTH-1:0]  rd_a_data, rd_b_data, fu_a, fu_b, fu_y, wr_data;
  logic              fu_sub, wr_valid, busy, done;
  logic              wr_ready = 1'b1;

  logic [31:0] mem    [NWORDS];
  logic [31:0] shadow [NWORDS];
  wrExp_t      sbQ[$];
  doneExp_t    doneQ[$];

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  int  writeCount = 0;
  int  lastDoneCyc = -1;
  int  cmdCount = 0;
  int  readyMode = 0;
  int  stallFrom = -1;
  int  stallTo = -2;
  bit  fillReq = 1'b0;

  fp_vaddsub_seq #(.WIDTH(WIDTH), .REG_AW(REG_AW), .ELEM_AW(ELEM_AW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2), .cmd_vd(cmd_vd),
    .cmd_vl(cmd_vl), .cmd_sub(cmd_sub),
    .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data),
    .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data),
    .fu_a(fu_a), .fu_b(fu_b), .fu_sub(fu_sub), .fu_y(fu_y),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  // Single precision <-> real for normal or zero values only.
  function automatic real spToReal(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] realToSp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] randVal();
    int k;
    k = int'($urandom_range(0, 4000)) - 2000;
    return realToSp(real'(k) * 0.5);
  endfunction

  assign rd_a_data = mem[rd_a_addr];
  assign rd_b_data = mem[rd_b_addr];

  // Stand-in FP unit: exact for the half-integer operands used here.
  always_comb begin
    fu_y = fu_sub ? realToSp(spToReal(fu_a) - spToReal(fu_b))
                  : realToSp(spToReal(fu_a) + spToReal(fu_b));
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port backpressure: an optional forced stall window plus optional
  // random refusals.
  always @(posedge clk) begin
    #1;
    wr_ready = !(cyc >= stallFrom && cyc <= stallTo) &&
               (readyMode == 0 || ($urandom % 4) != 0);
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: owns the VRF storage, consumes expected writes and done events.
  always @(negedge clk) begin
    if (fillReq) begin
      for (int k = 0; k < NWORDS; k++) mem[k] = shadow[k];
    end
    if (wr_valid && wr_ready) begin
      mem[wr_addr] = wr_data;
      writeCount++;
      if (sbQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_write actual addr=0x%0h data=0x%0h required none", wr_addr, wr_data);
      end else begin
        wrExp_t e;
        e = sbQ.pop_front();
        checkOutput("wr_addr", 64'(wr_addr), 64'(e.addr));
        checkOutput("wr_data", 64'(wr_data), 64'(e.data));
        if (e.cyc >= 0) checkOutput("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (done) begin
      lastDoneCyc = cyc;
      if (doneQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        doneExp_t d;
        d = doneQ.pop_front();
        if (d.cyc >= 0) checkOutput("done_cycle", 64'(cyc), 64'(d.cyc));
        checkOutput("done_writes_left", 64'(sbQ.size() > 0 && sbQ[0].cmdId == d.cmdId), 64'd0);
      end
    end
  end

  task automatic syncMem();
    @(posedge clk) #1 fillReq = 1'b1;
    @(negedge clk);
    @(posedge clk) #1 fillReq = 1'b0;
  endtask

  // Issues one command, waits for its acceptance and queues the model's
  // expectations: vd[i] = vs1[i] +/- vs2[i] for i < min(vl, 8), all operands
  // taken from the register state before the command.
  task automatic applyStimulus(input int vs1, input int vs2, input int vd, input int vl,
                               input bit sub, input bit timed, output int acceptEdge);
    int          vlEff;
    logic [31:0] res [8];
    bit          accepted;
    @(posedge clk) #1;
    cmd_vs1 = REG_AW'(vs1); cmd_vs2 = REG_AW'(vs2); cmd_vd = REG_AW'(vd);
    cmd_vl = (ELEM_AW+1)'(vl); cmd_sub = sub; cmd_valid = 1'b1;
    accepted = 1'b0;
    acceptEdge = -1;
    for (int t = 0; t < 300 && !accepted; t++) begin
      @(negedge clk);
      if (cmd_ready) accepted = 1'b1;
    end
    if (!accepted) begin
      checks++;
      failures++;
      $display("[TB] FAIL cmd_accept_timeout actual cmd_ready=0 required 1");
      cmd_valid = 1'b0;
      return;
    end
    acceptEdge = cyc + 1;
    cmdCount++;
    vlEff = (vl > 8) ? 8 : vl;
    for (int i = 0; i < vlEff; i++) begin
      real a, b;
      a = spToReal(shadow[vs1 * 8 + i]);
      b = spToReal(shadow[vs2 * 8 + i]);
      res[i] = realToSp(sub ? a - b : a + b);
    end
    for (int i = 0; i < vlEff; i++) begin
      wrExp_t e;
      shadow[vd * 8 + i] = res[i];
      e.cmdId = cmdCount;
      e.addr  = AW'(vd * 8 + i);
      e.data  = res[i];
      e.cyc   = timed ? acceptEdge + 2 + i : -1;
      sbQ.push_back(e);
    end
    begin
      doneExp_t d;
      d.cmdId = cmdCount;
      d.cyc   = !timed ? -1 : (vlEff == 0 ? acceptEdge : acceptEdge + vlEff + 2);
      doneQ.push_back(d);
    end
    @(posedge clk) #1 cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 600 && !idle; t++) begin
      @(negedge clk);
      if (sbQ.size() == 0 && doneQ.size() == 0 && cmd_ready) idle = 1'b1;
    end
    if (!idle) begin
      checks++;
      failures++;
      $display("[TB] FAIL idle_timeout actual pending=%0d/%0d required 0/0", sbQ.size(), doneQ.size());
      sbQ.delete();
      doneQ.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int acc, acc2, wc;
    logic [31:0] addExp [4];
    logic [31:0] subExp [4];
    logic [31:0] origA  [4];
    addExp = '{32'h3FC00000, 32'h40200000, 32'h40600000, 32'h40900000};
    subExp = '{32'h3F000000, 32'h3FC00000, 32'h40200000, 32'h40600000};
    origA  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};

    for (int k = 0; k < NWORDS; k++) shadow[k] = randVal();
    for (int i = 0; i < 8; i++) begin
      shadow[8 + i]  = (i < 4) ? origA[i] : randVal();
      shadow[16 + i] = 32'h3F000000;
    end
    fillReq = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    fillReq = 1'b0;
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_wr_valid", 64'(wr_valid), 64'd0);
    checkOutput("rst_rd_addrs", {32'(rd_a_addr), 32'(rd_b_addr)}, 64'd0);
    checkOutput("rst_fu_ops", {fu_a, fu_b}, 64'd0);
    checkOutput("rst_wr_addr", 64'(wr_addr), 64'd0);
    checkOutput("rst_wr_data", 64'(wr_data), 64'd0);
    @(posedge clk) #1 reset = 1'b0;

    // Directed add, no backpressure: writes in cycles 3..6, done in cycle 7
    applyStimulus(1, 2, 3, 4, 1'b0, 1'b1, acc);
    waitIdle();
    for (int i = 0; i < 4; i++) checkOutput("add_result", 64'(mem[24 + i]), 64'(addExp[i]));

    // Directed subtract
    applyStimulus(1, 2, 4, 4, 1'b1, 1'b1, acc);
    waitIdle();
    for (int i = 0; i < 4; i++) checkOutput("sub_result", 64'(mem[32 + i]), 64'(subExp[i]));

    // Three-cycle stall on the second write
    wc = writeCount;
    applyStimulus(1, 2, 3, 4, 1'b0, 1'b0, acc);
    stallFrom = acc + 3;
    stallTo   = acc + 5;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k >= 4) begin
        checkOutput("stall_wr_valid", 64'(wr_valid), 64'd1);
        checkOutput("stall_wr_addr", 64'(wr_addr), 64'd25);
        checkOutput("stall_wr_data", 64'(wr_data), 64'h40200000);
        checkOutput("stall_rd_addr", {32'(rd_a_addr), 32'(rd_b_addr)}, {32'd11, 32'd19});
      end
    end
    waitIdle();
    stallFrom = -1;
    stallTo   = -2;
    checkOutput("stall_done_cycle", 64'(lastDoneCyc), 64'(acc + 9));
    checkOutput("stall_write_count", 64'(writeCount - wc), 64'd4);
    for (int i = 0; i < 4; i++) checkOutput("stall_result", 64'(mem[24 + i]), 64'(addExp[i]));

    // vl = 0 and vl above the maximum
    wc = writeCount;
    applyStimulus(5, 6, 7, 0, 1'b0, 1'b1, acc);
    waitIdle();
    checkOutput("vl0_write_count", 64'(writeCount - wc), 64'd0);
    wc = writeCount;
    applyStimulus(5, 6, 7, 12, 1'b0, 1'b1, acc);
    waitIdle();
    checkOutput("vl12_write_count", 64'(writeCount - wc), 64'd8);

    // Reset in cycle 4 of a vl=8 command
    applyStimulus(1, 2, 10, 8, 1'b0, 1'b1, acc);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk) #1 reset = 1'b0;
    sbQ.delete();
    doneQ.delete();
    @(negedge clk);
    checkOutput("abort_wr_valid", 64'(wr_valid), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("abort_done", 64'(done), 64'd0);
    repeat (12) @(negedge clk);
    for (int k = 0; k < NWORDS; k++) shadow[k] = mem[k];
    applyStimulus(11, 12, 13, 5, 1'b1, 1'b1, acc);
    waitIdle();

    // Back-to-back with vd = vs1 aliasing: (A + 0.5) - 0.5 restores A
    applyStimulus(1, 2, 8, 4, 1'b0, 1'b1, acc);
    applyStimulus(8, 2, 8, 4, 1'b1, 1'b1, acc2);
    checkOutput("b2b_accept_edge", 64'(acc2), 64'(acc + 7));
    waitIdle();
    for (int i = 0; i < 4; i++) checkOutput("alias_result", 64'(mem[64 + i]), 64'(origA[i]));

    // Randomised batches, alternating free-flowing and random backpressure
    for (int batch = 0; batch < 6; batch++) begin
      readyMode = batch % 2;
      for (int j = 0; j < 4; j++) begin
        int vs1, vs2, vd;
        vs1 = int'($urandom % 32);
        vs2 = int'($urandom % 32);
        vd  = (($urandom % 4) == 0) ? vs1 : int'($urandom % 32);
        applyStimulus(vs1, vs2, vd, int'($urandom % 16), 1'($urandom % 2),
                      readyMode == 0, acc);
        if (($urandom % 2) == 0) waitIdle();
      end
      waitIdle();
    end
    readyMode = 0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_vaddsub_seq.md
Name: fp_vaddsub_seq

Overview:
Sequencer that runs one vector FP add/sub instruction (vd[i] = vs1[i] ± vs2[i], i = 0..vl-1) on the shared combinational FP add/sub unit. It sits between the coprocessor decode/issue stage and the vector register file (VRF). It accepts one command at a time, streams element reads from two async VRF read ports, drives the FP unit and writes results back. It runs a 2-stage pipeline at one element per cycle, with write-port backpressure.

Parameters:
WIDTH, 32, element width in bits (IEEE single precision).
REG_AW, 5, vector register index width (32 registers).
ELEM_AW, 3, element index width; MAXVL = 2**ELEM_AW = 8.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_vs1  input  REG_AW  source register A
cmd_vs2  input  REG_AW  source register B
cmd_vd  input  REG_AW  destination register
cmd_vl  input  ELEM_AW+1  element count, 0..2*MAXVL-1
cmd_sub  input  1  1 = subtract (A-B), 0 = add
rd_a_addr  output  REG_AW+ELEM_AW  {vs1, elem} async read address, port A
rd_a_data  input  WIDTH  combinational read data, port A
rd_b_addr  output  REG_AW+ELEM_AW  {vs2, elem} async read address, port B
rd_b_data  input  WIDTH  combinational read data, port B
fu_a  output  WIDTH  FP unit operand a
fu_b  output  WIDTH  FP unit operand b
fu_sub  output  1  FP unit subtract select
fu_y  input  WIDTH  FP unit combinational result
wr_valid  output  1  write request
wr_ready  input  1  write accepted this cycle
wr_addr  output  REG_AW+ELEM_AW  {vd, elem}
wr_data  output  WIDTH  result
busy  output  1  command in progress
done  output  1  one-cycle pulse, command complete

Behaviour:
- Reset (sync, high): state=IDLE; cmd_ready=1; busy=0; done=0; wr_valid=0; all pipeline valids=0; rd_*_addr, fu_*, wr_addr and wr_data all 0. Reset asserted mid-command aborts it: no further writes and no done pulse.
- States: IDLE, RUN, DRAIN.
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch vs1/vs2/vd/sub. Latch vl_eff = min(cmd_vl, MAXVL). rd_idx=0.
    - vl_eff=0: done=1 next cycle, stay IDLE, no writes.
    - Otherwise: go to RUN.
  - RUN: busy=1, cmd_ready=0. rd_*_addr = {vsX, rd_idx}. Each non-stalled cycle:
    - capture rd_a_data/rd_b_data into op_a/op_b (S1 valid) with elem tag;
    - rd_idx++.
    - After issuing index vl_eff-1, go to DRAIN.
  - DRAIN: no new reads. When S1 and S2 are both empty and the last write has handshaken: done=1 for one cycle, go to IDLE.
- Pipeline:
  - S1 regs (op_a, op_b, tag) drive fu_a, fu_b; fu_sub = latched sub.
  - S2 regs capture fu_y and tag. wr_valid = S2 valid; wr_data = S2 result; wr_addr = {vd, S2 tag}.
  - When S2 is empty, fu_a/fu_b still drive S1 content, or 0.
- Stall = wr_valid & ~wr_ready. On stall, freeze rd_idx, S1 and S2; addresses and wr_* are held stable. No element is dropped or duplicated.
- Timing: cycle 1 = first cycle after the accept edge. With no stalls:
  - element i is read in cycle 1+i and written in cycle 3+i;
  - done is asserted in cycle vl_eff+3;
  - throughput is 1 element/cycle.
- Elements are written in ascending order, exactly once each.
- cmd_ready is high in the done cycle, so back-to-back commands are allowed. A new accept in the done cycle starts reads next cycle.
- vd equal to vs1 or vs2 is legal: element i is read before it is written, and no other element aliases it.
- busy = (state != IDLE).
- NaN, inf and rounding behaviour belong entirely to the FP unit; the sequencer passes data unmodified.

Test Plan:
- vl=4, vs1=1 holding {1.0,2.0,3.0,4.0}, vs2=2 holding {0.5 x4}, add, vd=3, wr_ready=1 -> writes {3,0..3} = 0x3FC00000, 0x40200000, 0x40600000, 0x40900000 in cycles 3..6; done in cycle 7.
- Same operands, cmd_sub=1 -> vd = {0.5, 1.5, 2.5, 3.5} (0x3F000000, 0x3FC00000, 0x40200000, 0x40600000), ascending order.
- wr_ready low for 3 cycles at the second write -> wr_addr/wr_data hold {3,1}/0x40200000; rd addr frozen; 4 writes total; done delayed 3 cycles (cycle 10).
- cmd_vl=0 -> done one cycle after accept, no wr_valid; cmd_vl=12 -> exactly 8 writes (elem 0..7).
- Reset asserted in cycle 4 of a vl=8 command -> from the next cycle wr_valid=0, busy=0, cmd_ready=1, no done; next command runs correctly.
- Second command held valid during the first -> accepted in the first's done cycle; vd=vs1 aliasing yields correct elementwise results.
